mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits between the CPU MEM stage and the word-wide data memory.
- Accepts one load/store request at a time through a valid/ready handshake.
- Converts byte/halfword/word accesses into word reads and writes on the memory port. Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_ADDR_BITS, 12, byte-address bits backed by memory. Any nonzero request address bit at or above this index is out of range.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as misaligned)
- req_signed  input  1  load sign-extends when 1; ignored for stores
- req_addr  input  32  byte address
- req_wdata  input  32  store data; byte/halfword taken from the low bits
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  2  0 = ok, 1 = misaligned, 2 = out of range (misaligned takes priority)
- dmAddress  output  32  word-aligned address to memory, low 2 bits always 0
- dmWriteEnabled  output  1  memory write strobe
- dmWriteInput  output  32  memory write data
- dmReadResult  input  32  combinational read data for dmAddress

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All latched registers cleared.
  - Outputs: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_error = 0, dmAddress = 0, dmWriteEnabled = 0, dmWriteInput = 0.
- Byte lanes are little-endian: addr[1:0] = 0 selects bits 7:0, 3 selects bits 31:24. A halfword at addr[1] = 1 uses bits 31:16.
- Misaligned conditions: halfword with addr[0] = 1; word with addr[1:0] != 0; size 3.
- Handshake:
  - A request transfers on a rising edge when req_valid and req_ready are both high.
  - On transfer, the unit latches write, size, signed, addr and wdata.
  - Inputs are ignored in all other states.
- States:
  - IDLE: req_ready = 1. On transfer:
    - error -> DONE
    - load -> READ
    - word store -> WRITE, with merge register = wdata
    - sub-word store -> MERGE
  - READ: dmAddress = latched addr with low 2 bits cleared. The selected lane of dmReadResult is extended into rdata_reg. Next state DONE.
  - MERGE: dmAddress as in READ. merge_reg = dmReadResult with the addressed byte/halfword lane replaced by wdata[7:0] or wdata[15:0]. Next state WRITE.
  - WRITE: dmWriteEnabled = 1, dmWriteInput = merge_reg, dmAddress held. Next state DONE.
  - DONE: resp_valid = 1; resp_rdata and resp_error present for exactly this cycle. Next state IDLE.
- Latency in cycles, from the transfer edge to the resp_valid cycle:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
- Back-to-back: a new request may transfer on the edge that leaves DONE? No. req_ready rises in the IDLE cycle after DONE. Minimum spacing is therefore latency + 1.
- dmWriteEnabled is high only in WRITE, exactly one cycle per store. It is never high for loads or errors.
- Outside READ, MERGE and WRITE, dmAddress keeps its last value and dmWriteInput keeps merge_reg. Both are 0 after reset.
- Reset mid-operation: state drops to IDLE immediately and dmWriteEnabled goes low at once. An interrupted store performs no write unless a rising edge occurred while WRITE was active. No response is issued for the aborted request.
- resp_rdata for a store or an error is 0.

Test Plan:
- Memory word 0x10 = 0x8899AABB. Load byte signed at 0x11 -> resp_rdata = 0xFFFFFFAA, 2 cycles after transfer. Load byte unsigned at 0x13 -> 0x00000088.
- Same word. Load half signed at 0x12 -> 0xFFFF8899. Load word at 0x10 -> 0x8899AABB. dmWriteEnabled stays 0 throughout.
- Store byte 0x000000CC at 0x12 -> one MERGE cycle, then a single WRITE cycle with dmWriteInput = 0x88CCAABB. Reading 0x10 afterwards returns 0x88CCAABB.
- Store word 0x12345678 at 0x20 -> WRITE on the cycle after transfer, resp_valid the cycle after that. Half store at 0x23 -> resp_error = 1 one cycle after transfer, with no write. Word load at 0x1000 -> resp_error = 2.
- Assert reset asynchronously during MERGE of a byte store -> outputs return to reset values before the next edge and the memory word is unchanged. Next request is accepted normally.
- Hold req_valid continuously with four alternating loads and stores -> req_ready is low from each transfer until the IDLE cycle after DONE, and there is exactly one resp_valid pulse per request, in order.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-wide data memory; sub-word stores use read-modify-write.
// Latency from transfer edge to resp_valid: load 2, word store 2, sub-word store 3, error 1 cycles.
// Backpressure: req_ready is high only in IDLE, one request in flight; the response cannot be stalled.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake; req_write, req_size, req_signed, req_addr, req_wdata request fields
//   resp_valid              one-cycle completion pulse carrying resp_rdata (extended load data) and resp_error
//   dmAddress               word-aligned memory address
//   dmWriteEnabled          memory write strobe
//   dmWriteInput            memory write data
//   dmReadResult            combinational memory read data for dmAddress
module mem_access_unit #(
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_error,
  output logic [31:0] dmAddress,
  output logic        dmWriteEnabled,
  output logic [31:0] dmWriteInput,
  input  logic [31:0] dmReadResult
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  // Holds store data from transfer; MERGE overlays it onto the old memory word.
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  // Last address driven to memory, so dmAddress holds between accesses.
  logic [31:0] dm_addr_q, dm_addr_d;

  logic        misaligned, out_of_range;
  logic [31:0] word_addr;
  logic [4:0]  byte_sel;
  logic [4:0]  half_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  assign misaligned   = (req_size == 2'd3) ||
                        (req_size == 2'd1 && req_addr[0]) ||
                        (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign out_of_range = |req_addr[31:MEM_ADDR_BITS];

  assign word_addr = {addr_q[31:2], 2'b00};
  assign byte_sel  = {addr_q[1:0], 3'b000};
  assign half_sel  = {addr_q[1], 4'b0000};
  assign ld_byte   = dmReadResult[byte_sel +: 8];
  assign ld_half   = dmReadResult[half_sel +: 16];

  always_comb begin
    ld_ext = dmReadResult;
    case (size_q)
      2'd0:    ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_ext = dmReadResult;
    endcase
  end

  always_comb begin
    merged = dmReadResult;
    if (size_q == 2'd0) merged[byte_sel +: 8]  = merge_q[7:0];
    else                merged[half_sel +: 16] = merge_q[15:0];
  end

  always_comb begin
    state_d        = state_q;
    size_d         = size_q;
    signed_d       = signed_q;
    addr_d         = addr_q;
    merge_d        = merge_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    dm_addr_d      = dm_addr_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    dmWriteEnabled = 1'b0;
    dmAddress      = dm_addr_q;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          rdata_d  = '0;
          err_d    = misaligned ? 2'd1 : (out_of_range ? 2'd2 : 2'd0);
          if (req_write) merge_d = req_wdata;
          if (misaligned || out_of_range) state_d = DONE;
          else if (!req_write)            state_d = READ;
          else if (req_size == 2'd2)      state_d = WRITE;
          else                            state_d = MERGE;
        end
      end
      READ: begin
        dmAddress = word_addr;
        dm_addr_d = word_addr;
        rdata_d   = ld_ext;
        state_d   = DONE;
      end
      MERGE: begin
        dmAddress = word_addr;
        dm_addr_d = word_addr;
        merge_d   = merged;
        state_d   = WRITE;
      end
      WRITE: begin
        dmAddress      = word_addr;
        dm_addr_d      = word_addr;
        dmWriteEnabled = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      addr_q    <= '0;
      merge_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 2'd0;
      dm_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      addr_q    <= addr_d;
      merge_q   <= merge_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      dm_addr_q <= dm_addr_d;
    end
  end

  assign resp_rdata   = resp_valid ? rdata_q : '0;
  assign resp_error   = resp_valid ? err_q : 2'd0;
  assign dmWriteInput = merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a small word memory model.
// Each request's latency, response data, error code and write activity are checked.
// Also covers asynchronous reset mid-store and back-to-back requests with req_valid held high.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_error;
  logic [31:0] dmAddress;
  logic        dmWriteEnabled;
  logic [31:0] dmWriteInput;
  logic [31:0] dmReadResult;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.MEM_ADDR_BITS(12)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .dmAddress(dmAddress), .dmWriteEnabled(dmWriteEnabled), .dmWriteInput(dmWriteInput),
    .dmReadResult(dmReadResult)
  );

  always #5 clock = ~clock;

  assign dmReadResult = mem[dmAddress[11:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge. Issues one request and checks its whole life.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                        input int exp_lat, input logic [31:0] exp_rd, input logic [1:0] exp_err,
                        input int exp_wr, input logic [31:0] exp_wdat);
    int          waitc = 0;
    int          lat = 0;
    int          writes = 0;
    bit          ready_bad = 0;
    logic [31:0] wseen = '0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    while (!req_ready && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clock);
    #1;
    if (!hold) req_valid = 1'b0;
    do begin
      @(negedge clock);
      lat++;
      if (dmWriteEnabled) begin
        writes++;
        wseen = dmWriteInput;
      end
      if (req_ready) ready_bad = 1'b1;
    end while (!resp_valid && lat < 10);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, resp_rdata, exp_rd);
    check({tag, " error"}, {30'b0, resp_error}, {30'b0, exp_err});
    check({tag, " writes"}, writes, exp_wr);
    if (exp_wr > 0) check({tag, " wdata"}, wseen, exp_wdat);
    check({tag, " ready low while busy"}, {31'b0, ready_bad}, 32'd0);
    @(negedge clock);
    check({tag, " pulse end/ready"}, {30'b0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    bit stray;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[4] = 32'h8899AABB;
    fork
      forever begin
        @(posedge clock);
        if (dmWriteEnabled === 1'b1) mem[dmAddress[11:2]] = dmWriteInput;
      end
    join_none

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    check("reset ready/valid/we", {29'b0, req_ready, resp_valid, dmWriteEnabled}, 32'b100);
    check("reset rdata", resp_rdata, 32'h0);
    check("reset error", {30'b0, resp_error}, 32'h0);
    check("reset dmAddress", dmAddress, 32'h0);
    check("reset dmWriteInput", dmWriteInput, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    //     tag          wr    sz    sg    addr          wdata         hold lat rdata          err  wr wdata
    do_req("lb s 11",   1'b0, 2'd0, 1'b1, 32'h11,       32'h0,        0,   2,  32'hFFFFFFAA, 2'd0, 0, 32'h0);
    do_req("lbu 13",    1'b0, 2'd0, 1'b0, 32'h13,       32'h0,        0,   2,  32'h00000088, 2'd0, 0, 32'h0);
    do_req("lh s 12",   1'b0, 2'd1, 1'b1, 32'h12,       32'h0,        0,   2,  32'hFFFF8899, 2'd0, 0, 32'h0);
    do_req("lw 10",     1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        0,   2,  32'h8899AABB, 2'd0, 0, 32'h0);
    do_req("sb 12",     1'b1, 2'd0, 1'b0, 32'h12,       32'h000000CC, 0,   3,  32'h0,        2'd0, 1, 32'h88CCAABB);
    do_req("lw 10 b",   1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        0,   2,  32'h88CCAABB, 2'd0, 0, 32'h0);
    do_req("sw 20",     1'b1, 2'd2, 1'b0, 32'h20,       32'h12345678, 0,   2,  32'h0,        2'd0, 1, 32'h12345678);
    do_req("lhu 22",    1'b0, 2'd1, 1'b0, 32'h22,       32'h0,        0,   2,  32'h00001234, 2'd0, 0, 32'h0);
    do_req("sh 20",     1'b1, 2'd1, 1'b0, 32'h20,       32'hFFFFBEEF, 0,   3,  32'h0,        2'd0, 1, 32'h1234BEEF);
    do_req("lb s 21",   1'b0, 2'd0, 1'b1, 32'h21,       32'h0,        0,   2,  32'hFFFFFFBE, 2'd0, 0, 32'h0);
    do_req("sh 23 mis", 1'b1, 2'd1, 1'b0, 32'h23,       32'h0000FFFF, 0,   1,  32'h0,        2'd1, 0, 32'h0);
    do_req("lw 1000",   1'b0, 2'd2, 1'b0, 32'h1000,     32'h0,        0,   1,  32'h0,        2'd2, 0, 32'h0);
    do_req("size3",     1'b0, 2'd3, 1'b0, 32'h10,       32'h0,        0,   1,  32'h0,        2'd1, 0, 32'h0);
    do_req("sh 1001",   1'b1, 2'd1, 1'b0, 32'h1001,     32'h1,        0,   1,  32'h0,        2'd1, 0, 32'h0);

    // Reset asserted while a byte store sits in MERGE.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h00000055;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst mid ready/valid/we", {29'b0, req_ready, resp_valid, dmWriteEnabled}, 32'b100);
    check("rst mid dmAddress", dmAddress, 32'h0);
    check("rst mid dmWriteInput", dmWriteInput, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (resp_valid || dmWriteEnabled) stray = 1'b1;
    end
    check("rst no resp/write", {31'b0, stray}, 32'd0);
    do_req("lw 10 rst", 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        0,   2,  32'h88CCAABB, 2'd0, 0, 32'h0);

    // req_valid held high across four alternating requests.
    do_req("b2b lw",    1'b0, 2'd2, 1'b0, 32'h20,       32'h0,        1,   2,  32'h1234BEEF, 2'd0, 0, 32'h0);
    do_req("b2b sw",    1'b1, 2'd2, 1'b0, 32'h24,       32'hA5A5A5A5, 1,   2,  32'h0,        2'd0, 1, 32'hA5A5A5A5);
    do_req("b2b lbu",   1'b0, 2'd0, 1'b0, 32'h24,       32'h0,        1,   2,  32'h000000A5, 2'd0, 0, 32'h0);
    do_req("b2b sb",    1'b1, 2'd0, 1'b0, 32'h27,       32'h00000011, 1,   3,  32'h0,        2'd0, 1, 32'h11A5A5A5);
    req_valid = 1'b0;
    do_req("lw 24",     1'b0, 2'd2, 1'b0, 32'h24,       32'h0,        0,   2,  32'h11A5A5A5, 2'd0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
